// File: rtl/instruction_fetch_pkg.sv
// ProcessorStructs: types and constants shared by the fetch stage.
//   fetch_state_t - fetch controller states (FETCH, DROP)
//   fetch_entry_t - one prefetch queue entry {pc, instr}
//   NOP_INSTR     - word presented to the core when nothing is queued
//   PC_STEP       - byte distance between consecutive instruction words
// Entry field widths are fixed here, so the ibus/mbus parameters of the
// fetch stage must stay equal to IBUS/MBUS.
package ProcessorStructs;

  localparam int IBUS = 32;
  localparam int MBUS = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [MBUS-1:0] pc;
    logic [IBUS-1:0] instr;
  } fetch_entry_t;

  // MOV R0,R0
  localparam logic [IBUS-1:0] NOP_INSTR = 32'h2000_0000;
  localparam logic [MBUS-1:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/instruction_fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t used as the prefetch buffer.
//   clk, rst - clock, synchronous active-high reset
//   push     - write din at the tail (caller never pushes when full)
//   pop      - drop the head (caller never pops when empty)
//   flush    - empty the queue; wins over push and pop
//   din      - entry to push
//   count    - number of valid entries, 0..DEPTH
//   head     - oldest entry, read combinationally from the storage array
module fetch_queue
  import ProcessorStructs::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output fetch_entry_t head
);

  localparam logic [AW:0] ONE = 1;

  // DEPTH is a power of two, so the pointers wrap on their own.
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  fetch_entry_t  mem [DEPTH];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count gates every read of it, so
  // clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage feeding the Processor core.
//   clk, rst          - clock, synchronous active-high reset
//   imem_req/addr     - registered read request to instruction memory
//   imem_ack/rdata    - read completion, sampled while imem_req is high
//   stall             - core does not consume the head this cycle
//   redirect/_pc      - flush the queue and restart fetch at redirect_pc
//   instruction/pcDir - head-of-queue word and its address (NOP when empty)
//   valid             - the prefetch queue holds at least one word
module instruction_fetch
  import ProcessorStructs::*;
#(
  parameter int              ibus     = 32,
  parameter int              mbus     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [mbus-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [mbus-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ibus-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [mbus-1:0] redirect_pc,
  output logic [ibus-1:0] instruction,
  output logic [mbus-1:0] pcDir,
  output logic            valid
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t    state, state_n;
  logic            req_n;
  logic [mbus-1:0] addr_n;
  logic [mbus-1:0] target, target_n;   // redirect target held during DROP
  logic [mbus-1:0] last_pc;            // pcDir shown while the queue is empty
  logic [CW-1:0]   count, count_next;
  logic            push, pop;
  fetch_entry_t    head, din;
  logic [mbus-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[mbus-1:2], 2'b00};
  assign valid        = (count != '0);

  // Redirect wins over both ends of the queue; in DROP the returning word
  // belongs to the abandoned stream and is never pushed.
  assign pop  = valid && !stall && !redirect;
  assign push = (state == FETCH) && imem_req && imem_ack && !redirect;
  assign din  = '{pc: imem_addr, instr: imem_rdata};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    count_next = redirect ? '0 : count + CW'(push) - CW'(pop);
    state_n    = state;
    req_n      = imem_req;
    addr_n     = imem_addr;
    target_n   = target;

    if (redirect) begin
      if (imem_req && !imem_ack) begin
        // Old request still in flight: keep it on the bus and swallow its ack.
        state_n  = DROP;
        target_n = redirect_tgt;
      end else begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = redirect_tgt;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_req && imem_ack) addr_n = imem_addr + PC_STEP;
          // A pending request always has room, so this also holds it high.
          req_n = (count_next < FULL);
        end
        DROP: begin
          if (imem_ack) begin
            state_n = FETCH;
            req_n   = 1'b1;
            addr_n  = target;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      target    <= RESET_PC;
      last_pc   <= RESET_PC;
    end else begin
      state     <= state_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      target    <= target_n;
      if (pop) last_pc <= head.pc;
    end
  end

  assign instruction = valid ? head.instr : NOP_INSTR;
  assign pcDir       = valid ? head.pc    : last_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_instruction_fetch;
  import ProcessorStructs::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction;
  logic [31:0] pcDir;
  logic        valid;

  always #5 clk = ~clk;

  instruction_fetch #(.ibus(32), .mbus(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .pcDir       (pcDir),
    .valid       (valid)
  );

  // Reference model: a queue of {pc, word} plus the bus request it expects.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          m_req;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_target;
  logic [31:0] m_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return addr | 32'hE000_0000;
  endfunction

  // Applies the rules for one rising edge to the model, using the inputs
  // that were held across that edge.
  task automatic model_step();
    ent_t e;
    if (rst) begin
      mq.delete();
      m_req  = 0;
      m_drop = 0;
      m_addr = 32'h0;
      m_last = 32'h0;
    end else if (redirect) begin
      mq.delete();
      if (m_req && !imem_ack) begin
        m_drop   = 1;
        m_target = redirect_pc & ~32'h3;
      end else begin
        m_drop = 0;
        m_req  = 1;
        m_addr = redirect_pc & ~32'h3;
      end
    end else begin
      if (mq.size() > 0 && !stall) begin
        m_last = mq[0].pc;
        void'(mq.pop_front());
      end
      if (m_drop) begin
        if (imem_ack) begin
          m_drop = 0;
          m_req  = 1;
          m_addr = m_target;
        end
      end else begin
        if (m_req && imem_ack) begin
          e.pc    = m_addr;
          e.instr = imem_rdata;
          mq.push_back(e);
          m_addr = m_addr + 32'd4;
        end
        m_req = (mq.size() < DEPTH);
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", imem_req, m_req);
    check("imem_addr", imem_addr, m_addr);
    check("valid", valid, mq.size() > 0);
    check("instruction", instruction, mq.size() > 0 ? mq[0].instr : 32'h2000_0000);
    check("pcDir", pcDir, mq.size() > 0 ? mq[0].pc : m_last);
  endtask

  // Drive inputs 1ns after an edge, advance one edge, check 1ns later.
  task automatic cycle(input logic r, input logic a, input logic s,
                       input logic rd, input logic [31:0] rpc);
    rst         = r;
    imem_ack    = a;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = data_of(m_addr);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    m_addr = '0;

    // Reset held for three cycles, then the first request appears.
    repeat (3) cycle(1, 0, 0, 0, 0);
    check("reset_instr", instruction, 32'h2000_0000);
    check("reset_pcdir", pcDir, 32'h0);
    cycle(0, 0, 0, 0, 0);
    check("first_req", imem_req, 1'b1);

    // Streaming: one word per cycle, pcDir = 0,4,8,...
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 0);
      check("stream_pc", pcDir, 32'(4 * i));
      check("stream_word", instruction, data_of(32'(4 * i)));
    end

    // Stall fill: four pushes, then request drops with address 16.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (6) cycle(0, 1, 1, 0, 0);
    check("fill_req", imem_req, 1'b0);
    check("fill_addr", imem_addr, 32'd16);
    check("fill_head", pcDir, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1, 0, 0, 0);
      check("drain_pc", pcDir, 32'(4 * i));
      check("drain_valid", valid, 1'b1);
    end

    // Variable latency: ack three cycles after the request.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("lat_addr", imem_addr, 32'd0);
    check("lat_nop", instruction, 32'h2000_0000);
    cycle(0, 1, 0, 0, 0);
    check("lat_valid", valid, 1'b1);
    check("lat_word", instruction, 32'hE000_0000);

    // Redirect mid-flight with the request at 8 pending.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("mid_pending", imem_addr, 32'd8);
    cycle(0, 0, 0, 1, 32'h43);
    check("mid_flushed", valid, 1'b0);
    check("mid_hold", imem_addr, 32'd8);
    cycle(0, 1, 0, 0, 0);
    check("mid_target", imem_addr, 32'h40);
    check("mid_discard", valid, 1'b0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("mid_first_pc", pcDir, 32'h40);

    // Redirect on the same edge as an ack, then reset with a request pending.
    cycle(0, 1, 0, 1, 32'h100);
    check("same_addr", imem_addr, 32'h100);
    check("same_discard", valid, 1'b0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pcdir", pcDir, 32'h0);

    // Address wrap at the top of the address space.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 32'hFFFF_FFFB);
    repeat (3) cycle(0, 1, 0, 0, 0);
    check("wrap_pc", pcDir, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 499) == 0,
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 4,
            $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
